mem_arbiter: RTL and testbench

- Two-requester arbiter that shares one backing memory port between instruction fetch (imem) and data access (dmem).
- Sits between the pipeline memory interfaces and the single memory/cache adapter port.
- Captures single-cycle request pulses, serialises them onto the shared port, and routes each response back to its owner.
- Dmem has priority; a starvation counter bounds how long imem can be held off.

---
 rtl/mem_arbiter.sv | 180 ++++++++++++++++++
 tb/tb_mem_arbiter.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: serialises imem fetches and dmem accesses onto one
// shared memory port, dmem first, with a starvation bound that eventually lets imem through.
module mem_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] imem_addr,
    input  logic [3:0]  imem_rmask,
    output logic [31:0] imem_rdata,
    output logic        imem_resp,
    input  logic [31:0] dmem_addr,
    input  logic [3:0]  dmem_rmask,
    input  logic [3:0]  dmem_wmask,
    input  logic [31:0] dmem_wdata,
    output logic [31:0] dmem_rdata,
    output logic        dmem_resp,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_rmask,
    output logic [3:0]  mem_wmask,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_resp
);

    localparam int CW = $clog2(STARVE_LIMIT + 1);

    typedef enum logic [1:0] {IDLE, I_WAIT, D_WAIT} state_t;

    state_t state, state_next;

    logic          i_valid;
    logic [31:0]   i_addr;
    logic [3:0]    i_rmask;
    logic          d_valid;
    logic [31:0]   d_addr;
    logic [3:0]    d_rmask;
    logic [3:0]    d_wmask;
    logic [31:0]   d_wdata;
    logic [31:0]   hold_addr;
    logic [31:0]   hold_wdata;
    logic [CW-1:0] starve_cnt;

    logic i_req, d_req, i_done, d_done, starved, grant_i, grant_d;

    assign i_req   = (imem_rmask != 4'b0);
    assign d_req   = (dmem_rmask != 4'b0) || (dmem_wmask != 4'b0);
    assign i_done  = (state == I_WAIT) && mem_resp;
    assign d_done  = (state == D_WAIT) && mem_resp;
    assign starved = (starve_cnt == CW'(STARVE_LIMIT));

    // Slots stay valid while in flight, so in IDLE a valid slot is exactly a pending one.
    assign grant_i = (state == IDLE) && i_valid && (!d_valid || starved);
    assign grant_d = (state == IDLE) && d_valid && !grant_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        mem_addr   = 32'b0;
        mem_rmask  = 4'b0;
        mem_wmask  = 4'b0;
        mem_wdata  = 32'b0;
        imem_resp  = 1'b0;
        imem_rdata = 32'b0;
        dmem_resp  = 1'b0;
        dmem_rdata = 32'b0;
        case (state)
            IDLE: begin
                if (grant_d) begin
                    mem_addr   = d_addr;
                    mem_rmask  = d_rmask;
                    mem_wmask  = d_wmask;
                    mem_wdata  = d_wdata;
                    state_next = D_WAIT;
                end else if (grant_i) begin
                    mem_addr   = i_addr;
                    mem_rmask  = i_rmask;
                    state_next = I_WAIT;
                end
            end
            I_WAIT: begin
                mem_addr  = hold_addr;
                mem_wdata = hold_wdata;
                if (mem_resp) begin
                    imem_resp  = 1'b1;
                    imem_rdata = mem_rdata;
                    state_next = IDLE;
                end
            end
            D_WAIT: begin
                mem_addr  = hold_addr;
                mem_wdata = hold_wdata;
                if (mem_resp) begin
                    dmem_resp  = 1'b1;
                    dmem_rdata = mem_rdata;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
        // Outputs read as zero for the whole reset cycle, even mid-transaction.
        if (rst) begin
            mem_addr   = 32'b0;
            mem_rmask  = 4'b0;
            mem_wmask  = 4'b0;
            mem_wdata  = 32'b0;
            imem_resp  = 1'b0;
            imem_rdata = 32'b0;
            dmem_resp  = 1'b0;
            dmem_rdata = 32'b0;
        end
    end

    // A request arriving on its own completion cycle recaptures rather than clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            i_valid <= 1'b0;
            i_addr  <= 32'b0;
            i_rmask <= 4'b0;
            d_valid <= 1'b0;
            d_addr  <= 32'b0;
            d_rmask <= 4'b0;
            d_wmask <= 4'b0;
            d_wdata <= 32'b0;
        end else begin
            if (i_req && (!i_valid || i_done)) begin
                i_valid <= 1'b1;
                i_addr  <= imem_addr;
                i_rmask <= imem_rmask;
            end else if (i_done) begin
                i_valid <= 1'b0;
            end
            if (d_req && (!d_valid || d_done)) begin
                d_valid <= 1'b1;
                d_addr  <= dmem_addr;
                d_rmask <= dmem_rmask;
                d_wmask <= dmem_wmask;
                d_wdata <= dmem_wdata;
            end else if (d_done) begin
                d_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hold_addr  <= 32'b0;
            hold_wdata <= 32'b0;
            starve_cnt <= '0;
        end else begin
            if (grant_d) begin
                hold_addr  <= d_addr;
                hold_wdata <= d_wdata;
            end else if (grant_i) begin
                hold_addr  <= i_addr;
                hold_wdata <= 32'b0;
            end
            if (grant_i) begin
                starve_cnt <= '0;
            end else if (grant_d && i_valid && !starved) begin
                starve_cnt <= starve_cnt + 1'b1;
            end
        end
    end

    a_imem_busy: assert property (@(posedge clk) disable iff (rst)
        !(i_req && i_valid && !i_done));
    a_dmem_busy: assert property (@(posedge clk) disable iff (rst)
        !(d_req && d_valid && !d_done));
    a_dmem_rw: assert property (@(posedge clk) disable iff (rst)
        !((dmem_rmask != 4'b0) && (dmem_wmask != 4'b0)));

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: directed requests push expected issues/responses,
// a negedge monitor pops and compares them against what the DUT presents.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] imem_addr, imem_rdata, dmem_addr, dmem_wdata, dmem_rdata;
    logic [3:0]  imem_rmask, dmem_rmask, dmem_wmask, mem_rmask, mem_wmask;
    logic        imem_resp, dmem_resp, mem_resp;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  rmask;
        logic [3:0]  wmask;
        logic [31:0] wdata;
        int          chk;
        int          req_cycle;
    } issue_t;

    typedef struct {
        bit          is_d;
        logic [31:0] rdata;
    } resp_t;

    issue_t      exp_issue[$];
    resp_t       exp_resp[$];
    issue_t      cur;
    resp_t       er;
    bit          inflight = 1'b0;
    int          cycle = 0;
    int          last_resp_cycle = -10;
    int          req_cycle = 0;
    int          mem_lat = 3;
    int          n_checks = 0;
    int          n_fail = 0;
    logic [31:0] resp_addr;

    always #5 clk = ~clk;

    mem_arbiter #(.STARVE_LIMIT(2)) dut (
        .clk(clk), .rst(rst),
        .imem_addr(imem_addr), .imem_rmask(imem_rmask),
        .imem_rdata(imem_rdata), .imem_resp(imem_resp),
        .dmem_addr(dmem_addr), .dmem_rmask(dmem_rmask), .dmem_wmask(dmem_wmask),
        .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp),
        .mem_addr(mem_addr), .mem_rmask(mem_rmask), .mem_wmask(mem_wmask),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
    );

    always @(posedge clk) cycle <= cycle + 1;

    function automatic logic [31:0] mem_model(input logic [31:0] a);
        return (a == 32'h0000_1000) ? 32'h0000_0013 : (a ^ 32'hA5A5_0000);
    endfunction

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, req, cycle);
        end
    endtask

    task automatic flag_fail(input string name);
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s: got event, expected none (cycle %0d)", name, cycle);
    endtask

    // Memory model: answers each issue after mem_lat cycles, even if the access was abandoned.
    initial begin
        mem_resp  = 1'b0;
        mem_rdata = 32'b0;
        forever begin
            @(negedge clk);
            if (mem_rmask != 4'b0 || mem_wmask != 4'b0) begin
                resp_addr = mem_addr;
                repeat (mem_lat) @(posedge clk);
                #1 mem_resp = 1'b1;
                mem_rdata = mem_model(resp_addr);
                @(posedge clk);
                #1 mem_resp = 1'b0;
                mem_rdata = 32'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            inflight = 1'b0;
            check_output("rst_addr", mem_addr, 32'b0);
            check_output("rst_wdata", mem_wdata, 32'b0);
            check_output("rst_ctl", {22'b0, mem_rmask, mem_wmask, imem_resp, dmem_resp}, 32'b0);
            check_output("rst_rdata", imem_rdata | dmem_rdata, 32'b0);
        end else begin
            if (mem_rmask != 4'b0 || mem_wmask != 4'b0) begin
                if (exp_issue.size() == 0) begin
                    flag_fail("unexpected_issue");
                end else begin
                    cur = exp_issue.pop_front();
                    check_output("issue_addr", mem_addr, cur.addr);
                    check_output("issue_rmask", {28'b0, mem_rmask}, {28'b0, cur.rmask});
                    check_output("issue_wmask", {28'b0, mem_wmask}, {28'b0, cur.wmask});
                    check_output("issue_wdata", mem_wdata, cur.wdata);
                    if (cur.chk == 1) check_output("issue_after_req", 32'(cycle), 32'(cur.req_cycle + 1));
                    if (cur.chk == 2) check_output("issue_after_resp", 32'(cycle), 32'(last_resp_cycle + 1));
                    inflight = 1'b1;
                end
            end else if (inflight) begin
                check_output("hold_addr", mem_addr, cur.addr);
                check_output("hold_wdata", mem_wdata, cur.wdata);
            end
            if (imem_resp || dmem_resp) begin
                if (imem_resp && dmem_resp) flag_fail("double_resp");
                if (exp_resp.size() == 0) begin
                    flag_fail("unexpected_resp");
                end else begin
                    er = exp_resp.pop_front();
                    check_output("resp_owner", {31'b0, dmem_resp}, {31'b0, er.is_d});
                    check_output("resp_rdata", er.is_d ? dmem_rdata : imem_rdata, er.rdata);
                end
                inflight = 1'b0;
                last_resp_cycle = cycle;
            end
            if (!imem_resp) check_output("imem_rdata_idle", imem_rdata, 32'b0);
            if (!dmem_resp) check_output("dmem_rdata_idle", dmem_rdata, 32'b0);
        end
    end

    task automatic clear_inputs();
        imem_addr  = 32'b0;
        imem_rmask = 4'b0;
        dmem_addr  = 32'b0;
        dmem_rmask = 4'b0;
        dmem_wmask = 4'b0;
        dmem_wdata = 32'b0;
    endtask

    task automatic apply_stimulus(input bit i_en, input logic [31:0] ia, input logic [3:0] dr,
                                  input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dwd);
        @(posedge clk);
        #1;
        if (i_en) begin
            imem_addr  = ia;
            imem_rmask = 4'hF;
        end
        dmem_addr  = da;
        dmem_rmask = dr;
        dmem_wmask = dw;
        dmem_wdata = dwd;
        req_cycle  = cycle;
        @(posedge clk);
        #1 clear_inputs();
    endtask

    // Waits for the owner's completion and re-requests in that same cycle.
    task automatic react_request(input bit on_d, input logic [31:0] addr);
        bit seen;
        seen = 1'b0;
        for (int n = 0; n < 100 && !seen; n++) begin
            @(posedge clk);
            #2;
            seen = on_d ? dmem_resp : imem_resp;
        end
        if (!seen) flag_fail("react_timeout");
        if (on_d) begin
            dmem_addr  = addr;
            dmem_rmask = 4'hF;
        end else begin
            imem_addr  = addr;
            imem_rmask = 4'hF;
        end
        req_cycle = cycle;
        @(posedge clk);
        #1 clear_inputs();
    endtask

    task automatic push_issue(input logic [31:0] a, input logic [3:0] r, input logic [3:0] w,
                              input logic [31:0] wd, input int chk);
        exp_issue.push_back('{addr: a, rmask: r, wmask: w, wdata: wd, chk: chk, req_cycle: req_cycle});
    endtask

    task automatic push_resp(input bit is_d, input logic [31:0] rd);
        exp_resp.push_back('{is_d: is_d, rdata: rd});
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while ((exp_issue.size() != 0 || exp_resp.size() != 0) && n < 200) begin
            @(posedge clk);
            n++;
        end
        if (n >= 200) begin
            flag_fail("drain_timeout");
            exp_issue.delete();
            exp_resp.delete();
        end
        repeat (2) @(posedge clk);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        $display("[TB] imem read");
        apply_stimulus(1'b1, 32'h0000_1000, 4'h0, 4'h0, 32'h0, 32'h0);
        push_issue(32'h0000_1000, 4'hF, 4'h0, 32'h0, 1);
        push_resp(1'b0, 32'h0000_0013);
        wait_drain();

        $display("[TB] dmem write");
        apply_stimulus(1'b0, 32'h0, 4'h0, 4'h3, 32'h8000_0004, 32'hDEAD_BEEF);
        push_issue(32'h8000_0004, 4'h0, 4'h3, 32'hDEAD_BEEF, 1);
        push_resp(1'b1, 32'h25A5_0004);
        wait_drain();

        $display("[TB] simultaneous requests");
        apply_stimulus(1'b1, 32'h0000_2000, 4'hF, 4'h0, 32'h0000_3000, 32'h0);
        push_issue(32'h0000_3000, 4'hF, 4'h0, 32'h0, 1);
        push_issue(32'h0000_2000, 4'hF, 4'h0, 32'h0, 2);
        push_resp(1'b1, 32'hA5A5_3000);
        push_resp(1'b0, 32'hA5A5_2000);
        wait_drain();
        check_output("starve_after_pair", 32'(dut.starve_cnt), 32'd0);

        $display("[TB] starvation bound");
        apply_stimulus(1'b1, 32'h0000_4000, 4'hF, 4'h0, 32'h0000_5000, 32'h0);
        push_issue(32'h0000_5000, 4'hF, 4'h0, 32'h0, 1);
        push_resp(1'b1, 32'hA5A5_5000);
        react_request(1'b1, 32'h0000_5004);
        push_issue(32'h0000_5004, 4'hF, 4'h0, 32'h0, 2);
        push_resp(1'b1, 32'hA5A5_5004);
        react_request(1'b1, 32'h0000_5008);
        push_issue(32'h0000_4000, 4'hF, 4'h0, 32'h0, 2);
        push_issue(32'h0000_5008, 4'hF, 4'h0, 32'h0, 2);
        push_resp(1'b0, 32'hA5A5_4000);
        push_resp(1'b1, 32'hA5A5_5008);
        wait_drain();
        check_output("starve_after_bound", 32'(dut.starve_cnt), 32'd0);

        $display("[TB] imem back-to-back");
        mem_lat = 1;
        apply_stimulus(1'b1, 32'h0000_6000, 4'h0, 4'h0, 32'h0, 32'h0);
        push_issue(32'h0000_6000, 4'hF, 4'h0, 32'h0, 1);
        push_resp(1'b0, 32'hA5A5_6000);
        for (int k = 1; k < 4; k++) begin
            react_request(1'b0, 32'h0000_6000 + 32'(4 * k));
            push_issue(32'h0000_6000 + 32'(4 * k), 4'hF, 4'h0, 32'h0, 2);
            push_resp(1'b0, 32'hA5A5_6000 + 32'(4 * k));
        end
        wait_drain();

        $display("[TB] reset during D_WAIT");
        mem_lat = 4;
        apply_stimulus(1'b0, 32'h0, 4'hF, 4'h0, 32'h0000_7000, 32'h0);
        push_issue(32'h0000_7000, 4'hF, 4'h0, 32'h0, 1);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        check_output("issue_queue_after_rst", 32'(exp_issue.size()), 32'd0);
        mem_lat = 3;
        apply_stimulus(1'b1, 32'h0000_1000, 4'h0, 4'h0, 32'h0, 32'h0);
        push_issue(32'h0000_1000, 4'hF, 4'h0, 32'h0, 1);
        push_resp(1'b0, 32'h0000_0013);
        wait_drain();

        check_output("resp_queue_empty", 32'(exp_resp.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "[TB] watchdog");
    end

endmodule
